// File: rtl/ram_sp_req_bridge_pkg.sv
// Shared types and elaboration-time parameter checks for ram_sp_req_bridge.
// The optional address check is enabled with RAM_SP_REQ_BRIDGE_ADDR_CHECK_EN.
package ram_sp_req_bridge_pkg;

    // One slot of the read-latency pipe: a request waiting for RAM data.
    typedef struct packed {
        logic valid;
        logic is_wr;
        logic err;
    } pipe_stage_t;

    function automatic bit legal_read_latency(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic bit legal_fifo_depth(input int unsigned depth, input int unsigned lat);
        return (depth >= lat + 1) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/ram_sp_req_bridge_fifo.sv
// First-word-fall-through FIFO with occupancy count; the head entry is
// visible on o_pop_data whenever o_empty is low.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_async_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign o_empty    = (count == '0);
    assign o_full     = (count == (PTR_W + 1)'(DEPTH));
    assign o_count    = count;
    assign o_pop_data = mem[rd_ptr];
    assign do_pop     = i_pop & ~o_empty;
    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_push    = i_push & (~o_full | do_pop);

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_push_data;
    end

    no_push_when_full: assert property (@(posedge i_clk) disable iff (i_async_rst) !(i_push && o_full));

endmodule

// File: rtl/ram_sp_req_bridge.sv
// Request/response bridge driving a single-port write-first RAM port.
// Define RAM_SP_REQ_BRIDGE_ADDR_CHECK_EN to flag misaligned/out-of-range requests.
module ram_sp_req_bridge
    import ram_sp_req_bridge_pkg::*;
#(
    parameter int WORD_BIT_WIDTH     = 32,
    parameter int DEPTH              = 8,
    parameter int READ_LATENCY       = 1,
    parameter int RSP_FIFO_DEPTH     = 4,
    parameter int REQ_ADDR_BIT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_async_rst,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic                          i_req_is_wr,
    input  logic [REQ_ADDR_BIT_WIDTH-1:0] i_req_byte_addr,
    input  logic [WORD_BIT_WIDTH-1:0]     i_req_wdata,
    input  logic [WORD_BIT_WIDTH/8-1:0]   i_req_wstrb,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [WORD_BIT_WIDTH-1:0]     o_rsp_rdata,
    output logic                          o_rsp_is_wr,
    output logic                          o_rsp_err,
    output logic                          o_ram_we,
    output logic [$clog2(DEPTH)-1:0]      o_ram_word_addr,
    output logic [WORD_BIT_WIDTH-1:0]     o_ram_data,
    output logic [WORD_BIT_WIDTH/8-1:0]   o_ram_wr_byte_en,
    input  logic [WORD_BIT_WIDTH-1:0]     i_ram_data
);
    localparam int OFF_W   = $clog2(WORD_BIT_WIDTH / 8);
    localparam int WADDR_W = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(RSP_FIFO_DEPTH) + 1;
    localparam int OUT_W   = CNT_W + 1;

    if (!legal_read_latency(READ_LATENCY)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (!legal_fifo_depth(RSP_FIFO_DEPTH, READ_LATENCY)) begin : g_bad_fifo_depth
        $error("RSP_FIFO_DEPTH must be a power of 2 and at least READ_LATENCY+1");
    end

    // Width follows WORD_BIT_WIDTH, so this entry type lives with the parameter.
    typedef struct packed {
        logic [WORD_BIT_WIDTH-1:0] rdata;
        logic                      is_wr;
        logic                      err;
    } rsp_entry_t;

    // Both streams transfer on a rising edge where valid & ready are high; valid never
    // waits for ready, payload is held while valid & !ready, and ready ignores valid.
    logic                  accept;
    logic                  req_err;
    logic                  pop;
    logic [OUT_W-1:0]      inflight;
    logic [OUT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    pipe_stage_t           pipe [READ_LATENCY];
    pipe_stage_t           last;
    rsp_entry_t            push_entry;
    rsp_entry_t            head;

`ifdef RAM_SP_REQ_BRIDGE_ADDR_CHECK_EN
    localparam logic [REQ_ADDR_BIT_WIDTH-1:0] OFF_MASK = REQ_ADDR_BIT_WIDTH'((1 << OFF_W) - 1);
    assign req_err = ((i_req_byte_addr & OFF_MASK) != '0)
                   || ((i_req_byte_addr >> (OFF_W + WADDR_W)) != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_req_byte_addr;
    assign req_err          = 1'b0;
`endif

    assign accept           = i_req_valid & o_req_ready;
    assign o_ram_we         = accept & i_req_is_wr & ~req_err;
    assign o_ram_word_addr  = i_req_byte_addr[OFF_W +: WADDR_W];
    assign o_ram_data       = accept ? i_req_wdata : '0;
    assign o_ram_wr_byte_en = accept ? i_req_wstrb : '0;

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: accept, is_wr: i_req_is_wr, err: req_err};
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign last       = pipe[READ_LATENCY-1];
    assign push_entry = '{rdata: (last.is_wr | last.err) ? '0 : i_ram_data,
                          is_wr: last.is_wr, err: last.err};

    // Every accepted request holds a credit until its response is popped.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + OUT_W'(pipe[i].valid);
    end

    assign pop         = o_rsp_valid & i_rsp_ready;
    assign outstanding = inflight + OUT_W'(fifo_count);
    assign o_req_ready = (outstanding - OUT_W'(pop)) < OUT_W'(RSP_FIFO_DEPTH);

    sync_fifo_fwft #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .i_clk       (i_clk),
        .i_async_rst (i_async_rst),
        .i_push      (last.valid),
        .i_push_data (push_entry),
        .i_pop       (pop),
        .o_pop_data  (head),
        .o_empty     (fifo_empty),
        .o_full      (fifo_full),
        .o_count     (fifo_count)
    );

    // Storage is not reset, so the payload is masked while nothing is queued.
    assign o_rsp_valid = ~fifo_empty;
    assign o_rsp_rdata = o_rsp_valid ? head.rdata : '0;
    assign o_rsp_is_wr = o_rsp_valid & head.is_wr;
    assign o_rsp_err   = o_rsp_valid & head.err;

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_ram_sp_req_bridge.sv
// Self-checking bench for ram_sp_req_bridge with a behavioural write-first RAM.
// Also covers the RAM_SP_REQ_BRIDGE_ADDR_CHECK_EN build.
module tb_ram_sp_req_bridge;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int RL    = 2;
    localparam int FD    = 4;
    localparam int AW    = 16;
    localparam int BW    = W / 8;
    localparam int OFF_W = 2;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [BW-1:0] strb;
        logic [W-1:0]  exp_rdata;
        logic          exp_err;
    } vec_t;

    logic          i_clk = 1'b0;
    logic          i_async_rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_is_wr;
    logic [AW-1:0] i_req_byte_addr;
    logic [W-1:0]  i_req_wdata;
    logic [BW-1:0] i_req_wstrb;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [W-1:0]  o_rsp_rdata;
    logic          o_rsp_is_wr;
    logic          o_rsp_err;
    logic          o_ram_we;
    logic [2:0]    o_ram_word_addr;
    logic [W-1:0]  o_ram_data;
    logic [BW-1:0] o_ram_wr_byte_en;
    logic [W-1:0]  i_ram_data;

    ram_sp_req_bridge #(
        .WORD_BIT_WIDTH     (W),
        .DEPTH              (DEPTH),
        .READ_LATENCY       (RL),
        .RSP_FIFO_DEPTH     (FD),
        .REQ_ADDR_BIT_WIDTH (AW)
    ) dut (
        .i_clk            (i_clk),
        .i_async_rst      (i_async_rst),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_is_wr      (i_req_is_wr),
        .i_req_byte_addr  (i_req_byte_addr),
        .i_req_wdata      (i_req_wdata),
        .i_req_wstrb      (i_req_wstrb),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (i_rsp_ready),
        .o_rsp_rdata      (o_rsp_rdata),
        .o_rsp_is_wr      (o_rsp_is_wr),
        .o_rsp_err        (o_rsp_err),
        .o_ram_we         (o_ram_we),
        .o_ram_word_addr  (o_ram_word_addr),
        .o_ram_data       (o_ram_data),
        .o_ram_wr_byte_en (o_ram_wr_byte_en),
        .i_ram_data       (i_ram_data)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    // ---------------- behavioural write-first RAM ----------------
    logic [W-1:0] ram [DEPTH];
    logic [W-1:0] ram_q1;
    logic [W-1:0] ram_q2;
    always @(posedge i_clk) begin
        if (o_ram_we)
            for (int b = 0; b < BW; b++)
                if (o_ram_wr_byte_en[b]) ram[o_ram_word_addr][8*b +: 8] = o_ram_data[8*b +: 8];
        ram_q1 <= ram[o_ram_word_addr];
        ram_q2 <= ram_q1;
    end
    assign i_ram_data = (RL == 1) ? ram_q1 : ram_q2;

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    logic [W-1:0] ref_mem [DEPTH];
    int checks   = 0;
    int failures = 0;
    int rsp_cnt  = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    logic         hold_prev = 1'b0;
    logic [W+1:0] hold_snap;
    logic [W+1:0] exp_entry;
    always @(negedge i_clk) begin
        if (i_async_rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if ({o_rsp_valid, o_rsp_rdata, o_rsp_is_wr, o_rsp_err} !== {1'b1, hold_snap}) begin
                    failures++;
                    $display("FAIL rsp_stable: got v=%b %h, required v=1 %h", o_rsp_valid,
                             {o_rsp_rdata, o_rsp_is_wr, o_rsp_err}, hold_snap);
                end
            end
            if (o_rsp_valid && i_rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stale_rsp: got rdata=%h is_wr=%b err=%b, required no response",
                             o_rsp_rdata, o_rsp_is_wr, o_rsp_err);
                end else begin
                    exp_entry = exp_q.pop_front();
                    if ({o_rsp_rdata, o_rsp_is_wr, o_rsp_err} !== exp_entry) begin
                        failures++;
                        $display("FAIL rsp_data: got %h, required %h",
                                 {o_rsp_rdata, o_rsp_is_wr, o_rsp_err}, exp_entry);
                    end
                end
                rsp_cnt++;
            end
            hold_prev = o_rsp_valid && !i_rsp_ready;
            hold_snap = {o_rsp_rdata, o_rsp_is_wr, o_rsp_err};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Entered and left at #1 after a rising edge; consumes one edge per accept.
    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] data,
                        input logic [BW-1:0] strb, input logic [W-1:0] exp_rdata,
                        input logic exp_err);
        int waited = 0;
        i_req_valid     = 1'b1;
        i_req_is_wr     = wr;
        i_req_byte_addr = addr;
        i_req_wdata     = data;
        i_req_wstrb     = strb;
        @(negedge i_clk);
        while (!o_req_ready && waited < 200) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_req_ready) begin
            failures++;
            $display("FAIL req_timeout: got ready=0 for 200 cycles, required ready=1");
            @(posedge i_clk);
            #1 i_req_valid = 1'b0;
            return;
        end
        check_eq("ram_we", 64'(o_ram_we), 64'(wr & ~exp_err));
        if (!exp_err) check_eq("ram_word_addr", 64'(o_ram_word_addr), 64'(addr[OFF_W +: 3]));
        if (wr && !exp_err) check_eq("ram_byte_en", 64'(o_ram_wr_byte_en), 64'(strb));
        @(posedge i_clk);
        exp_q.push_back({exp_rdata, wr, exp_err});
        if (wr && !exp_err)
            for (int b = 0; b < BW; b++)
                if (strb[b]) ref_mem[addr[OFF_W +: 3]][8*b +: 8] = data[8*b +: 8];
        #1 i_req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            step(1);
            waited++;
        end
        check_eq("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- test ----------------
    vec_t vecs [12];
    int   acc;
    int   c0;
    int   n;
    int   base;
    logic [W-1:0] d;

    initial begin
        vecs[0]  = '{1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 16'h0000, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 16'h0000, 32'h0000AA00, 4'h2, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h1122AA44, 1'b0};
        vecs[5]  = '{1'b1, 16'h001C, 32'h0BADF00D, 4'hF, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 16'h001C, 32'h00000077, 4'h1, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 16'h001C, 32'h0,        4'h0, 32'h0BADF077, 1'b0};
`ifdef RAM_SP_REQ_BRIDGE_ADDR_CHECK_EN
        vecs[8]  = '{1'b0, 16'h0002, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 16'h1000, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 16'h1004, 32'hCAFEBABE, 4'hF, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1};
        vecs[11].exp_err = 1'b0;
        vecs[11].addr    = 16'h0008;
`else
        vecs[8]  = '{1'b0, 16'h0002, 32'h0,        4'h0, 32'h1122AA44, 1'b0};
        vecs[9]  = '{1'b0, 16'h1000, 32'h0,        4'h0, 32'h1122AA44, 1'b0};
        vecs[10] = '{1'b1, 16'h0004, 32'hCAFEBABE, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'hCAFEBABE, 1'b0};
`endif

        i_async_rst     = 1'b1;
        i_req_valid     = 1'b0;
        i_req_is_wr     = 1'b0;
        i_req_byte_addr = '0;
        i_req_wdata     = '0;
        i_req_wstrb     = '0;
        i_rsp_ready     = 1'b1;
        step(3);
        check_eq("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check_eq("rst_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
        check_eq("rst_rsp_is_wr", 64'(o_rsp_is_wr), 64'd0);
        check_eq("rst_rsp_err",   64'(o_rsp_err),   64'd0);
        check_eq("rst_req_ready", 64'(o_req_ready), 64'd1);
        check_eq("rst_ram_we",    64'(o_ram_we),    64'd0);
        i_async_rst = 1'b0;
        step(2);

        // Table-driven vectors, responses checked by the scoreboard.
        for (int i = 0; i < 12; i++)
            send(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].exp_rdata, vecs[i].exp_err);
        drain();

        // Accept-to-response latency of a single read.
        send(1'b0, 16'h0008, '0, '0, 32'hDEADBEEF, 1'b0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_rsp_valid) break;
            @(posedge i_clk);
            n++;
        end
        check_eq("read_latency_edges", 64'(n), 64'(RL));
        step(1);
        drain();

        // 16 alternating write/read requests, one accept per cycle.
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            send(1'b1, AW'(i * 4), d, 4'hF, '0, 1'b0);
            send(1'b0, AW'(i * 4), '0, '0, d, 1'b0);
        end
        check_eq("stream_cycles", 64'(cyc - c0), 64'd16);
        drain();

        // Back-pressure: only FD reads fit, then release and finish the burst.
        i_rsp_ready = 1'b0;
        acc         = 0;
        i_req_valid = 1'b1;
        i_req_is_wr = 1'b0;
        i_req_wdata = '0;
        i_req_wstrb = '0;
        for (int c = 0; c < 12; c++) begin
            i_req_byte_addr = AW'(acc * 4);
            @(negedge i_clk);
            if (o_req_ready) begin
                @(posedge i_clk);
                exp_q.push_back({ref_mem[acc], 2'b00});
                acc++;
            end else begin
                @(posedge i_clk);
            end
            #1;
        end
        check_eq("bp_accepted", 64'(acc), 64'(FD));
        check_eq("bp_req_ready", 64'(o_req_ready), 64'd0);
        check_eq("bp_rsp_valid", 64'(o_rsp_valid), 64'd1);
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            i_req_byte_addr = AW'(acc * 4);
            @(negedge i_clk);
            if (o_req_ready) begin
                @(posedge i_clk);
                exp_q.push_back({ref_mem[acc], 2'b00});
                acc++;
            end else begin
                @(posedge i_clk);
            end
            #1;
        end
        i_req_valid = 1'b0;
        check_eq("bp_total", 64'(acc), 64'd8);
        drain();

        // Reset with three reads outstanding.
        i_rsp_ready = 1'b0;
        send(1'b0, 16'h0000, '0, '0, ref_mem[0], 1'b0);
        send(1'b0, 16'h0004, '0, '0, ref_mem[1], 1'b0);
        send(1'b0, 16'h0008, '0, '0, ref_mem[2], 1'b0);
        #2 i_async_rst = 1'b1;
        #1;
        check_eq("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check_eq("midrst_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
        exp_q.delete();
        base = rsp_cnt;
        step(2);
        i_async_rst = 1'b0;
        i_rsp_ready = 1'b1;
        step(10);
        check_eq("post_rst_no_rsp", 64'(rsp_cnt - base), 64'd0);
        send(1'b0, 16'h0008, '0, '0, ref_mem[2], 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
